// File: rtl/loop_stack.sv
// ============================================================================
//  Module   : loop_stack
//  Purpose  : Hardware return-address stack for the bfcpu loop unit. Holds
//             the addresses of open '[' brackets, tracks its own depth and
//             presents the top entry with zero read latency.
//  Revision : 1.0  initial release
//
//  Ports
//    clk        in   1           rising-edge clock
//    rst_n      in   1           synchronous active-low reset
//    push       in   1           push push_data this cycle
//    pop        in   1           pop the top entry this cycle
//    push_data  in   DATA_WIDTH  entry to push
//    flush      in   1           discard all entries
//    err_clr    in   1           clear sticky error flags
//    top        out  DATA_WIDTH  current top entry, 0 when empty
//    count      out  CNT_WIDTH   number of valid entries
//    empty      out  1           count == 0
//    full       out  1           count == DEPTH
//    overflow   out  1           push rejected because the stack was full
//    underflow  out  1           pop rejected because the stack was empty
//
//  Build option
//    LOOP_STACK_STICKY_ERR_EN : when defined, overflow/underflow hold until
//                               err_clr or reset; otherwise they are
//                               one-cycle pulses and err_clr is ignored.
// ============================================================================
`default_nettype none

module loop_stack #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_TWO   = CNT_WIDTH'(2);

  // Entries below the two held in registers live in RAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] r_top;
  logic [DATA_WIDTH-1:0] r_under;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_do_pop;
  logic                  w_do_repl;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  // Push+pop on an empty stack degrades to a plain push (the pop is the
  // offending half), so it is folded into w_do_push.
  assign w_do_push = ~flush & push & (~pop | w_empty) & ~w_full;
  assign w_do_pop  = ~flush & pop & ~push & ~w_empty;
  assign w_do_repl = ~flush & push & pop & ~w_empty;

  assign w_ovf_evt = ~flush & push & ~pop & w_full;
  assign w_udf_evt = ~flush & pop & w_empty;

  // The old top spills to RAM slot count-1; nothing spills from empty.
  // Gated by rst_n so a push on a reset edge leaves RAM untouched.
  assign w_we      = rst_n & w_do_push & ~w_empty;
  assign w_wr_addr = r_count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  // On a pop the new under-top is entry (count-1)-2 = count-3. Only used
  // when count >= 3, so the modulo-2^ADDR_WIDTH subtraction never wraps.
  assign w_rd_addr = r_count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_addr] <= r_top;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_top   <= '0;
      r_under <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      // Under-top comes straight from the old top, never from RAM, so a
      // same-edge write/read on one address can not matter.
      r_under <= r_top;
      r_top   <= push_data;
      r_count <= r_count + C_ONE;
    end else if (w_do_repl) begin
      r_top   <= push_data;
    end else if (w_do_pop) begin
      if (r_count == C_ONE) begin
        r_top   <= '0;
        r_under <= '0;
      end else begin
        r_top   <= r_under;
        // Synchronous RAM read issued on the popping edge itself.
        r_under <= (r_count == C_TWO) ? '0 : r_mem[w_rd_addr];
      end
      r_count <= r_count - C_ONE;
    end
  end

`ifdef LOOP_STACK_STICKY_ERR_EN
  // A fresh error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~err_clr);
      r_udf <= w_udf_evt | (r_udf & ~err_clr);
    end
  end
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt;
      r_udf <= w_udf_evt;
    end
  end
`endif

  assign top       = r_top;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_loop_stack.sv
// ============================================================================
//  Module   : tb_loop_stack
//  Purpose  : Directed scoreboard bench for loop_stack (DEPTH=4). Each
//             stimulus step queues its hand-computed expected state; a
//             monitor pops and compares after every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_loop_stack;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef LOOP_STACK_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] top;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  typedef struct {
    int            id;
    logic [DW-1:0] top;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          udf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  loop_stack #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_data(push_data),
    .flush    (flush),
    .err_clr  (err_clr),
    .top      (top),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", id, name, act, req);
    end
  endtask

  // Monitor: one expected record per clocked step, compared 1 time unit
  // after the edge that should have produced it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("top",       e.id, 32'(top),       32'(e.top));
      check("count",     e.id, 32'(count),     32'(e.cnt));
      check("empty",     e.id, 32'(empty),     32'(e.cnt == 0));
      check("full",      e.id, 32'(full),      32'(e.cnt == CW'(DEPTH)));
      check("overflow",  e.id, 32'(overflow),  32'(e.ovf));
      check("underflow", e.id, 32'(underflow), 32'(e.udf));
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input logic r, input logic fl, input logic ps,
                      input logic pp, input logic clr, input logic [DW-1:0] d,
                      input logic [DW-1:0] et, input logic [CW-1:0] ec,
                      input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    rst_n     = r;
    flush     = fl;
    push      = ps;
    pop       = pp;
    err_clr   = clr;
    push_data = d;
    e.id  = step_id;
    e.top = et;
    e.cnt = ec;
    e.ovf = eo;
    e.udf = eu;
    exp_q.push_back(e);
    step_id++;
  endtask

  initial begin
    //    rst fl ps pp clr data      top      cnt ovf     udf
    step(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0,      0);      // 0 reset
    step(1, 0, 1, 0, 0, 16'h0010, 16'h0010, 1, 0,      0);      // 1
    step(1, 0, 1, 0, 0, 16'h0020, 16'h0020, 2, 0,      0);      // 2
    step(1, 0, 1, 0, 0, 16'h0030, 16'h0030, 3, 0,      0);      // 3
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0020, 2, 0,      0);      // 4 pop
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0010, 1, 0,      0);      // 5 pop
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0,      0);      // 6 pop -> empty
    step(1, 0, 1, 0, 0, 16'h0001, 16'h0001, 1, 0,      0);      // 7
    step(1, 0, 1, 0, 0, 16'h0002, 16'h0002, 2, 0,      0);      // 8
    step(1, 0, 1, 0, 0, 16'h0003, 16'h0003, 3, 0,      0);      // 9
    step(1, 0, 1, 0, 0, 16'h0004, 16'h0004, 4, 0,      0);      // 10 full
    step(1, 0, 1, 0, 0, 16'h0005, 16'h0004, 4, 1,      0);      // 11 overflow
    step(1, 0, 0, 0, 0, 16'h0000, 16'h0004, 4, STICKY, 0);      // 12 idle
    step(1, 0, 1, 0, 1, 16'h0006, 16'h0004, 4, 1,      0);      // 13 new err beats clr
    step(1, 0, 0, 0, 1, 16'h0000, 16'h0004, 4, 0,      0);      // 14 clr
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0003, 3, 0,      0);      // 15 LIFO
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0002, 2, 0,      0);      // 16
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0001, 1, 0,      0);      // 17
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0,      0);      // 18
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0,      1);      // 19 underflow
    step(1, 0, 1, 1, 0, 16'h0077, 16'h0077, 1, 0,      1);      // 20 push+pop empty
    step(1, 0, 0, 0, 0, 16'h0000, 16'h0077, 1, 0,      STICKY); // 21 idle
    step(1, 0, 0, 0, 1, 16'h0000, 16'h0077, 1, 0,      0);      // 22 clr
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0,      0);      // 23
    step(1, 0, 1, 0, 0, 16'h000A, 16'h000A, 1, 0,      0);      // 24
    step(1, 0, 1, 0, 0, 16'h000B, 16'h000B, 2, 0,      0);      // 25
    step(1, 0, 1, 1, 0, 16'h000C, 16'h000C, 2, 0,      0);      // 26 replace
    step(1, 0, 0, 1, 0, 16'h0000, 16'h000A, 1, 0,      0);      // 27
    step(1, 0, 1, 0, 0, 16'h000B, 16'h000B, 2, 0,      0);      // 28
    step(1, 0, 1, 0, 0, 16'h000D, 16'h000D, 3, 0,      0);      // 29
    step(1, 1, 1, 0, 0, 16'h00EE, 16'h0000, 0, 0,      0);      // 30 flush+push
    step(1, 0, 1, 0, 0, 16'h0011, 16'h0011, 1, 0,      0);      // 31
    step(1, 0, 1, 0, 0, 16'h0022, 16'h0022, 2, 0,      0);      // 32
    step(0, 0, 1, 0, 0, 16'h0033, 16'h0000, 0, 0,      0);      // 33 reset mid-push
    step(1, 0, 1, 0, 0, 16'h0044, 16'h0044, 1, 0,      0);      // 34
    step(1, 0, 1, 0, 0, 16'h0055, 16'h0055, 2, 0,      0);      // 35
    step(1, 0, 1, 1, 0, 16'h0066, 16'h0066, 2, 0,      0);      // 36 replace
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0044, 1, 0,      0);      // 37
    step(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0,      0);      // 38

    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    err_clr = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
